pipe_reg_chain: RTL and testbench

//   Parametrised elastic register pipeline: DEPTH stages of WIDTH-bit data, each with a valid bit.

---
 rtl/pipe_reg_chain.sv | 105 ++++++++++
 tb/tb_pipe_reg_chain.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// Elastic register pipeline: DEPTH valid/data stages with bubble collapse and synchronous flush.
// Latency: DEPTH cycles from input handshake to out_valid when there is no stall.
// Backpressure: the ready chain is combinational from out_ready back to in_ready, so a full chain with out_ready=1 still accepts.
module pipe_reg_chain #(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]            r_valid;
  logic [DEPTH-1:0][WIDTH-1:0] r_data;
  logic [CW-1:0]               r_count;

  logic [DEPTH-1:0]            w_adv;
  logic [DEPTH-1:0]            w_src_valid;
  logic [DEPTH-1:0][WIDTH-1:0] w_src_data;
  logic [DEPTH-1:0]            w_valid_nxt;
  logic [CW-1:0]               w_count_nxt;
  logic                        w_in_ready;

  // Stage i may advance unless it and every stage downstream of it are full while the output is stalled.
  // Written in closed form so the chain is not a self-referencing vector.
  always_comb begin
    w_adv = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic all_full;
      all_full = 1'b1;
      for (int j = i; j < DEPTH; j++) begin
        all_full = all_full & r_valid[j];
      end
      w_adv[i] = out_ready | ~all_full;
    end
  end

  assign w_in_ready = w_adv[0] & ~flush & ~rst;

  // Source of each stage: the input port for stage 0, otherwise the previous stage.
  always_comb begin
    w_src_valid    = '0;
    w_src_data     = '0;
    w_src_valid[0] = in_valid & w_in_ready;
    w_src_data[0]  = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      w_src_valid[i] = r_valid[i-1];
      w_src_data[i]  = r_data[i-1];
    end
  end

  // Next-state valid vector and its popcount, so count is registered alongside valid.
  always_comb begin
    w_valid_nxt = '0;
    w_count_nxt = '0;
    if (!rst && !flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        w_valid_nxt[i] = w_adv[i] ? w_src_valid[i] : r_valid[i];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_count_nxt = w_count_nxt + CW'(w_valid_nxt[i]);
    end
  end

  // Stage registers: data only loads when a valid item moves in, and flush leaves data untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_data  <= {DEPTH{RESET_VAL}};
      r_count <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_count <= w_count_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        if (!flush && w_adv[i] && w_src_valid[i]) begin
          r_data[i] <= w_src_data[i];
        end
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_valid[DEPTH-1];
  assign out_data  = r_data[DEPTH-1];
  assign count     = r_count;

  // A stalled output must stay valid and stable unless flushed or reset.
  a_out_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

  // Occupancy can never exceed the number of stages.
  a_count_range: assert property (@(posedge clk) r_count <= CW'(DEPTH));

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain with a scoreboard queue of accepted items.
// Inputs change on the falling edge; outputs are checked away from the rising edge.
module tb_pipe_reg_chain;

  localparam int               WIDTH = 16;
  localparam int               DEPTH = 3;
  localparam logic [WIDTH-1:0] RVAL  = 16'hA5A5;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       count;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  logic [WIDTH-1:0] sb[$];

  pipe_reg_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RVAL)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check ready model, record handshakes in the scoreboard, advance to the next falling edge.
  task automatic tick();
    logic ihs, ohs, exp_ir;
    logic [WIDTH-1:0] exp_d;
    #1;
    exp_ir = ((sb.size() < DEPTH) || out_ready) && !flush && !rst;
    chk("in_ready_model", in_ready, exp_ir);
    ihs = in_valid && in_ready;
    ohs = out_valid && out_ready && !rst;
    if (ohs) begin
      if (sb.size() == 0) begin
        chk("spurious_out", out_data, 32'hFFFF_FFFF);
      end else begin
        exp_d = sb.pop_front();
        chk("out_order", out_data, exp_d);
        n_out++;
      end
    end
    if (ihs) sb.push_back(in_data);
    if (rst || flush) sb.delete();
    @(negedge clk);
    chk("count_model", count, sb.size());
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int g = 0; g < 10 && (sb.size() != 0 || out_valid); g++) tick();
    chk(tag, sb.size(), 0);
    chk("drain_out_valid", out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset held for two cycles
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, RVAL);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1'b1);

    // Back-to-back stream with output always ready
    n_out = 0;
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1;
      in_data  = 16'(k);
      tick();
      chk("stream_latency", out_valid, (k >= DEPTH));
    end
    in_valid = 1'b0;
    tick(); chk("stream_tail1", out_valid, 1'b1);
    tick(); chk("stream_tail2", out_valid, 1'b1);
    tick(); chk("stream_empty", out_valid, 1'b0);
    chk("stream_n_out", n_out, 8);
    chk("empty_holds_data", out_data, 16'h0008);

    // Backpressure: fill, stall, then release
    n_out = 0;
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1;
      in_data  = 16'h0010 + 16'(k);
      tick();
    end
    in_data = 16'h0014;
    #1;
    chk("bp_full_in_ready", in_ready, 1'b0);
    chk("bp_full_count", count, 3);
    tick();
    chk("bp_hold_data", out_data, 16'h0011);
    chk("bp_hold_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_same_cycle", in_ready, 1'b1);
    tick();
    in_data = 16'h0015;
    tick();
    drain("bp_drained");
    chk("bp_n_out", n_out, 5);

    // Bubble collapse with output stalled
    n_out = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0021;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("bub_first_at_out", out_valid, 1'b1);
    in_valid = 1'b1; in_data = 16'h0022;
    tick();
    in_valid = 1'b0;
    tick();
    chk("bub_count2", count, 2);
    chk("bub_stage_map", dut.r_valid, 3'b110);
    tick();
    chk("bub_holds", dut.r_valid, 3'b110);
    chk("bub_out_data", out_data, 16'h0021);
    in_valid = 1'b1; in_data = 16'h0023;
    tick();
    in_valid = 1'b0;
    chk("bub_full", dut.r_valid, 3'b111);
    drain("bub_drained");
    chk("bub_n_out", n_out, 3);

    // Flush while full and stalled, with a concurrent input that must be dropped
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1;
      in_data  = 16'h0030 + 16'(k);
      tick();
    end
    flush = 1'b1; in_data = 16'hDEAD;
    #1;
    chk("flush_in_ready", in_ready, 1'b0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_data_kept", out_data, 16'h0031);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("flush_no_ghost", out_valid, 1'b0);
    end

    // Flush coinciding with an output handshake still delivers that item
    n_out = 0;
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1;
      in_data  = 16'h0040 + 16'(k);
      tick();
    end
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_hs_delivered", n_out, 1);
    chk("flush_hs_empty", out_valid, 1'b0);

    // Reset during a full stall, then a fresh item
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1;
      in_data  = 16'h0050 + 16'(k);
      tick();
    end
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_out_valid", out_valid, 1'b0);
    chk("mrst_out_data", out_data, RVAL);
    chk("mrst_count", count, 0);
    n_out = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 16'h0061;
    tick();
    in_valid = 1'b0;
    chk("mrst_lat1", out_valid, 1'b0);
    tick();
    chk("mrst_lat2", out_valid, 1'b0);
    tick();
    chk("mrst_lat3", out_valid, 1'b1);
    chk("mrst_data", out_data, 16'h0061);
    tick();
    chk("mrst_n_out", n_out, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
